data_memory_sized: RTL and testbench
====================================

// Module: data_memory_sized
// PURPOSE
//  Clocked, parametrised data memory for the MIPS datapath MEM stage; successor to the
//  combinational 16x32 array. Adds byte/half/word access with sign/zero extension,
//  per-lane writes, registered 1-cycle reads, a valid/ready request handshake,
//  alignment/range error reporting and a post-reset clear sequence.
// PARAMETERS
//  DATA_W  32   data word width; fixed at 32 (4 byte lanes, little-endian lane order)
//  DEPTH   256  number of words; power of two, >= 4
//  IDX_W   8    log2(DEPTH); word index = address[IDX_W+1:2]
// PORTS
//  clk         in   1       single clock, all state updates on rising edge
//  reset       in   1       asynchronous, active-high reset
//  req_valid   in   1       request present this cycle
//  req_ready   out  1       block can accept a request (1 only in RUN state)
//  req_write   in   1       1 = store, 0 = load
//  req_size    in   2       00 byte, 01 half, 10 word, 11 illegal
//  req_signed  in   1       loads: 1 sign-extend, 0 zero-extend (ignored for stores/word)
//  address     in   32      byte address
//  writedata   in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  resp_valid  out  1       1-cycle pulse, one per accepted request, no backpressure
//  resp_err    out  2       00 ok, 01 misaligned, 10 out of range, 11 illegal size
//  readdata    out  32      load result, extended; 0 for stores and errored requests
// BEHAVIOUR
//  - Reset (async assert): state=CLEAR, clr_ptr=0, req_ready=0, resp_valid=0,
//    resp_err=0, readdata=0. Any in-flight response is dropped; CLEAR restarts.
//  - CLEAR: writes 0 to mem[clr_ptr] each cycle, clr_ptr++; after DEPTH cycles
//    (clr_ptr==DEPTH-1 written) -> RUN. Exactly DEPTH cycles with req_ready=0.
//  - RUN: req_ready=1 every cycle; request accepted when req_valid && req_ready.
//    Accept rate 1/cycle; response for request at edge N is visible after edge N+1
//    (resp_valid high for exactly one cycle, fixed 1-cycle latency).
//  - Error check priority: illegal size (11) > misaligned > out of range.
//    Misaligned: half with address[0]=1, word with address[1:0]!=0.
//    Out of range: any of address[31:IDX_W+2] nonzero.
//    Errored request: memory unchanged, resp_valid=1, readdata=0, resp_err set.
//  - Store: byte -> lane address[1:0] gets writedata[7:0]; half -> lanes
//    {address[1],0}/{address[1],1} get writedata[15:0]; word -> all lanes. Other
//    lanes untouched. Committed at the accepting edge; resp readdata=0, err=00.
//  - Load: selected byte/half shifted to [7:0]/[15:0], upper bits = sign bit if
//    req_signed else 0; word returned as-is.
//  - Back-to-back store then load to same word: load sees the stored value (store
//    committed at edge N, load reads at edge N+1). No same-cycle bypass needed.
//  - req_valid while req_ready=0 (CLEAR): ignored, no response generated.
//  - Inputs other than req_valid are don't-care when not accepted.
// TESTING
//  1 Reset then wait: req_ready=0 for exactly 256 cycles, then 1; load word @0x3FC
//    -> readdata=0x00000000, err=00 (clear worked).
//  2 Store word 0x8899AABB @0x10; store byte 0x7F @0x11; load word @0x10
//    -> 0x88997FBB; load byte signed @0x13 -> 0xFFFFFF88; unsigned -> 0x00000088.
//  3 Store half 0x8001 @0x22; load half signed @0x22 -> 0xFFFF8001, unsigned
//    -> 0x00008001; load word @0x20 -> 0x80010000.
//  4 Load word @0x02 -> err=01; store half @0x05 -> err=01, mem unchanged;
//    load word @0x400 -> err=10; size=11 @0x401 -> err=11; readdata=0 each.
//  5 Back-to-back: store word 0x12345678 @0x40 cycle N, load word @0x40 cycle N+1
//    -> resp_valid both N+1 and N+2, second readdata=0x12345678.
//  6 Assert reset while a load response is pending -> resp_valid stays 0,
//    req_ready=0, CLEAR reruns; previously written @0x40 reads 0 afterwards.

Source files
------------

// File: rtl/data_memory_sized_if.sv
// Request/response bus for the MEM-stage data memory: one request per cycle when
// ready, one fixed-latency response pulse per accepted request.
interface data_memory_sized_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] address;
   logic [31:0] writedata;
   logic        resp_valid;
   logic [1:0]  resp_err;
   logic [31:0] readdata;

   modport master (
      output req_valid, req_write, req_size, req_signed, address, writedata,
      input  req_ready, resp_valid, resp_err, readdata
   );

   modport slave (
      input  req_valid, req_write, req_size, req_signed, address, writedata,
      output req_ready, resp_valid, resp_err, readdata
   );
endinterface

// File: rtl/data_memory_sized.sv
// Clocked byte/half/word data memory with per-lane writes, registered reads,
// alignment/range error reporting and a zero-fill sequence after reset.
module data_memory_sized #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 256,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input logic                clk,
   input logic                reset,
   data_memory_sized_if.slave bus
);
   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [0:0]        state_reg;
   logic [IDX_W-1:0]  clr_ptr_reg;
   logic              resp_valid_reg;
   logic [1:0]        resp_err_reg;
   logic              load_reg;
   logic [1:0]        size_reg;
   logic              signed_reg;
   logic [1:0]        off_reg;

   logic              accept;
   logic              rd_en;
   logic [1:0]        req_err;
   logic [IDX_W-1:0]  req_idx;
   logic [3:0]        wr_en;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] raw_word;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [DATA_W-1:0] rdata;

   assign accept  = bus.req_valid && (state_reg == ST_RUN);
   assign req_idx = bus.address[IDX_W+1:2];

   // Illegal size outranks misalignment, which outranks out-of-range.
   always_comb begin
      req_err = 2'b00;
      if (bus.req_size == 2'b11)
         req_err = 2'b11;
      else if ((bus.req_size == 2'b01 && bus.address[0]) ||
               (bus.req_size == 2'b10 && bus.address[1:0] != 2'b00))
         req_err = 2'b01;
      else if (|bus.address[31:IDX_W+2])
         req_err = 2'b10;
   end

   assign rd_en = accept && !bus.req_write && (req_err == 2'b00);

   // Store data is replicated across lanes so each lane only needs its enable.
   always_comb begin
      wr_en   = 4'b0000;
      wr_idx  = req_idx;
      wr_data = bus.writedata;
      if (state_reg == ST_CLEAR) begin
         wr_en   = 4'b1111;
         wr_idx  = clr_ptr_reg;
         wr_data = '0;
      end else if (accept && bus.req_write && (req_err == 2'b00)) begin
         case (bus.req_size)
            2'b00: begin
               wr_en   = 4'b0001 << bus.address[1:0];
               wr_data = {4{bus.writedata[7:0]}};
            end
            2'b01: begin
               wr_en   = bus.address[1] ? 4'b1100 : 4'b0011;
               wr_data = {2{bus.writedata[15:0]}};
            end
            default: wr_en = 4'b1111;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] lane_mem [DEPTH];
         logic [7:0] rd_reg;

         always_ff @(posedge clk) begin
            if (wr_en[gi])
               lane_mem[wr_idx] <= wr_data[gi*8 +: 8];
            if (rd_en)
               rd_reg <= lane_mem[req_idx];
         end

         assign raw_word[gi*8 +: 8] = rd_reg;
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg      <= ST_CLEAR;
         clr_ptr_reg    <= '0;
         resp_valid_reg <= 1'b0;
         resp_err_reg   <= 2'b00;
         load_reg       <= 1'b0;
         size_reg       <= 2'b00;
         signed_reg     <= 1'b0;
         off_reg        <= 2'b00;
      end else begin
         if (state_reg == ST_CLEAR) begin
            clr_ptr_reg <= clr_ptr_reg + 1'b1;
            if (clr_ptr_reg == IDX_W'(DEPTH - 1))
               state_reg <= ST_RUN;
         end
         resp_valid_reg <= accept;
         resp_err_reg   <= accept ? req_err : 2'b00;
         load_reg       <= rd_en;
         if (rd_en) begin
            size_reg   <= bus.req_size;
            signed_reg <= bus.req_signed;
            off_reg    <= bus.address[1:0];
         end
      end
   end

   assign byte_sel = raw_word[{off_reg, 3'b000} +: 8];
   assign half_sel = off_reg[1] ? raw_word[31:16] : raw_word[15:0];

   always_comb begin
      rdata = '0;
      if (load_reg) begin
         case (size_reg)
            2'b00:   rdata = {{24{signed_reg & byte_sel[7]}}, byte_sel};
            2'b01:   rdata = {{16{signed_reg & half_sel[15]}}, half_sel};
            default: rdata = raw_word;
         endcase
      end
   end

   assign bus.req_ready  = (state_reg == ST_RUN);
   assign bus.resp_valid = resp_valid_reg;
   assign bus.resp_err   = resp_err_reg;
   assign bus.readdata   = rdata;
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: clear sequence, sized loads/stores,
// error codes, back-to-back store/load and reset during a pending response.
module tb_data_memory_sized;
   logic clk = 1'b0;
   logic reset;

   data_memory_sized_if bus();

   data_memory_sized #(.DATA_W(32), .DEPTH(256)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One request, accepted at the next rising edge; response sampled 1 time unit later.
   task automatic xact(input string tag, input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic [1:0] exp_err);
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_size   = sz;
      bus.req_signed = sgn;
      bus.address    = addr;
      bus.writedata  = wd;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      $display("[TB] %s wr=%0d sz=%0d sgn=%0d addr=0x%08h wd=0x%08h -> vld=%0d err=%0d rd=0x%08h",
               tag, wr, sz, sgn, addr, wd, bus.resp_valid, bus.resp_err, bus.readdata);
      chk({tag, ".vld"}, {31'd0, bus.resp_valid}, 32'd1);
      chk({tag, ".err"}, {30'd0, bus.resp_err}, {30'd0, exp_err});
      chk({tag, ".rd"}, bus.readdata, exp_rd);
   endtask

   // Counts rising edges until req_ready appears; also flags any response during CLEAR.
   task automatic wait_ready(output int n, output int stray);
      n = 0;
      stray = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         #1;
         n++;
         if (bus.resp_valid) stray++;
         if (bus.req_ready) break;
      end
      bus.req_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int stray;

      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_size   = 2'b10;
      bus.req_signed = 1'b0;
      bus.address    = 32'h0;
      bus.writedata  = 32'h0;
      reset = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("rst.ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst.vld", {31'd0, bus.resp_valid}, 32'd0);
      chk("rst.err", {30'd0, bus.resp_err}, 32'd0);
      chk("rst.rd", bus.readdata, 32'd0);

      // Test 1: clear takes 256 cycles; requests during CLEAR are ignored.
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_size  = 2'b10;
      bus.address   = 32'h0000_0010;
      wait_ready(n, stray);
      $display("[TB] clear: ready after %0d cycles, stray responses %0d", n, stray);
      chk("t1.clear_cycles", n, 32'd256);
      chk("t1.no_resp_in_clear", stray, 32'd0);
      xact("t1.ld_w_3fc", 1'b0, 2'b10, 1'b0, 32'h0000_03FC, 32'h0, 32'h0000_0000, 2'b00);

      // Test 2: word store, byte overwrite, byte loads.
      xact("t2.st_w_10", 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'h8899_AABB, 32'h0, 2'b00);
      xact("t2.st_b_11", 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_007F, 32'h0, 2'b00);
      xact("t2.ld_w_10", 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 32'h8899_7FBB, 2'b00);
      xact("t2.ld_bs_13", 1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'h0, 32'hFFFF_FF88, 2'b00);
      xact("t2.ld_bu_13", 1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0, 32'h0000_0088, 2'b00);
      xact("t2.ld_bs_11", 1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0, 32'h0000_007F, 2'b00);

      // Test 3: upper half store and loads.
      xact("t3.st_h_22", 1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_8001, 32'h0, 2'b00);
      xact("t3.ld_hs_22", 1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0, 32'hFFFF_8001, 2'b00);
      xact("t3.ld_hu_22", 1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0, 32'h0000_8001, 2'b00);
      xact("t3.ld_w_20", 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 32'h8001_0000, 2'b00);

      // Test 4: error codes; errored store must leave memory alone.
      xact("t4.st_w_04", 1'b1, 2'b10, 1'b0, 32'h0000_0004, 32'hCAFE_F00D, 32'h0, 2'b00);
      xact("t4.ld_w_02", 1'b0, 2'b10, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 2'b01);
      xact("t4.st_h_05", 1'b1, 2'b01, 1'b0, 32'h0000_0005, 32'h0000_1234, 32'h0, 2'b01);
      xact("t4.ld_w_04", 1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 2'b00);
      xact("t4.ld_w_400", 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 2'b10);
      xact("t4.sz3_401", 1'b0, 2'b11, 1'b0, 32'h0000_0401, 32'h0, 32'h0, 2'b11);
      xact("t4.st_w_400", 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0, 2'b10);
      xact("t4.ld_w_000", 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 32'h0, 2'b00);

      // Test 5: back-to-back store then load to the same word.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b1;
      bus.req_size   = 2'b10;
      bus.req_signed = 1'b0;
      bus.address    = 32'h0000_0040;
      bus.writedata  = 32'h1234_5678;
      @(posedge clk);
      #1;
      $display("[TB] t5.st_w_40 vld=%0d err=%0d rd=0x%08h", bus.resp_valid, bus.resp_err, bus.readdata);
      chk("t5.st.vld", {31'd0, bus.resp_valid}, 32'd1);
      chk("t5.st.rd", bus.readdata, 32'd0);
      bus.req_write = 1'b0;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      $display("[TB] t5.ld_w_40 vld=%0d err=%0d rd=0x%08h", bus.resp_valid, bus.resp_err, bus.readdata);
      chk("t5.ld.vld", {31'd0, bus.resp_valid}, 32'd1);
      chk("t5.ld.rd", bus.readdata, 32'h1234_5678);
      @(posedge clk);
      #1;
      chk("t5.idle.vld", {31'd0, bus.resp_valid}, 32'd0);

      // Test 6: reset lands while a load response is showing.
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_size  = 2'b10;
      bus.address   = 32'h0000_0040;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      reset = 1'b1;
      #1;
      $display("[TB] t6.reset_mid_resp vld=%0d ready=%0d rd=0x%08h", bus.resp_valid, bus.req_ready, bus.readdata);
      chk("t6.vld", {31'd0, bus.resp_valid}, 32'd0);
      chk("t6.ready", {31'd0, bus.req_ready}, 32'd0);
      chk("t6.rd", bus.readdata, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      wait_ready(n, stray);
      $display("[TB] re-clear: ready after %0d cycles, stray responses %0d", n, stray);
      chk("t6.clear_cycles", n, 32'd256);
      chk("t6.no_resp_in_clear", stray, 32'd0);
      xact("t6.ld_w_40", 1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h0000_0000, 2'b00);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
